fetch_redirect_ctrl: RTL and testbench



---
 rtl/mips_core_pkg.sv | 19 +
 rtl/sat_counter.sv | 19 +
 rtl/fetch_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared types and counter widths for the fetch redirect controller
package mips_core_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_EX   = 2'd2
  } redirect_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } redirect_state_t;

  localparam int STAT_REDIRECTS_W   = 32;
  localparam int STAT_HELD_W        = 32;
  localparam int STAT_EX_OVERRIDE_W = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - sequences EX/ID redirects into fetch load_pc; FETCH_REDIRECT_STATS_EN adds counters
module fetch_redirect_ctrl
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_ex_valid,
  input  logic [ADDR_WIDTH-1:0] i_ex_pc,
  input  logic                  i_id_valid,
  input  logic [ADDR_WIDTH-1:0] i_id_pc,
  output logic                  o_load_we,
  output logic [ADDR_WIDTH-1:0] o_load_pc,
  output logic                  o_flush_if,
  output logic                  o_flush_id,
  output logic                  o_pending
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [STAT_REDIRECTS_W-1:0]   o_stat_redirects,
  output logic [STAT_HELD_W-1:0]        o_stat_held_cycles,
  output logic [STAT_EX_OVERRIDE_W-1:0] o_stat_ex_overrides
`endif
);

  redirect_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  redirect_src_t         pend_src_q, pend_src_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_pc_q  <= '0;
      pend_src_q <= SRC_NONE;
    end else begin
      state_q    <= state_d;
      pend_pc_q  <= pend_pc_d;
      pend_src_q <= pend_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    pend_src_d = pend_src_q;
    o_load_we  = 1'b0;
    o_load_pc  = '0;
    o_flush_if = 1'b0;
    o_flush_id = 1'b0;
    o_pending  = 1'b0;
    case (state_q)
      IDLE: begin
        // Load is driven even when stalled; fetch ignores it and we replay from HELD.
        if (i_ex_valid) begin
          o_load_we  = 1'b1;
          o_load_pc  = i_ex_pc;
          o_flush_if = 1'b1;
          o_flush_id = 1'b1;
          if (i_stall) begin
            state_d    = HELD;
            pend_pc_d  = i_ex_pc;
            pend_src_d = SRC_EX;
          end
        end else if (i_id_valid) begin
          o_load_we  = 1'b1;
          o_load_pc  = i_id_pc;
          o_flush_if = 1'b1;
          if (i_stall) begin
            state_d    = HELD;
            pend_pc_d  = i_id_pc;
            pend_src_d = SRC_ID;
          end
        end
      end
      HELD: begin
        o_pending = 1'b1;
        o_load_we = 1'b1;
        o_load_pc = pend_pc_q;
        // ID requests are dropped here: the pending redirect is older or the same jump.
        if (i_ex_valid) begin
          o_load_pc  = i_ex_pc;
          o_flush_if = 1'b1;
          o_flush_id = 1'b1;
          pend_pc_d  = i_ex_pc;
          pend_src_d = SRC_EX;
        end
        if (!i_stall) begin
          state_d    = IDLE;
          pend_src_d = SRC_NONE;
        end
      end
      default: begin
        state_d    = IDLE;
        pend_src_d = SRC_NONE;
      end
    endcase
  end

`ifdef FETCH_REDIRECT_STATS_EN
  logic accept, held, ex_override;

  assign accept      = i_ex_valid || (i_id_valid && (state_q == IDLE));
  assign held        = (state_q == HELD);
  assign ex_override = i_ex_valid && held && (pend_src_q == SRC_ID);

  sat_counter #(.WIDTH(STAT_REDIRECTS_W)) u_cnt_redirects (
    .clk   (clk),
    .inc   (accept),
    .clr   (rst),
    .count (o_stat_redirects)
  );

  sat_counter #(.WIDTH(STAT_HELD_W)) u_cnt_held (
    .clk   (clk),
    .inc   (held),
    .clr   (rst),
    .count (o_stat_held_cycles)
  );

  sat_counter #(.WIDTH(STAT_EX_OVERRIDE_W)) u_cnt_ex_overrides (
    .clk   (clk),
    .inc   (ex_override),
    .clr   (rst),
    .count (o_stat_ex_overrides)
  );
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - vector table, directed sequences and random model check for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst, stall, ex_v, id_v;
  logic [AW-1:0] ex_pc, id_pc;
  logic          load_we, flush_if, flush_id, pending;
  logic [AW-1:0] load_pc;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0]   stat_redirects, stat_held;
  logic [15:0]   stat_ovr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_stall    (stall),
    .i_ex_valid (ex_v),
    .i_ex_pc    (ex_pc),
    .i_id_valid (id_v),
    .i_id_pc    (id_pc),
    .o_load_we  (load_we),
    .o_load_pc  (load_pc),
    .o_flush_if (flush_if),
    .o_flush_id (flush_id),
    .o_pending  (pending)
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    .o_stat_redirects    (stat_redirects),
    .o_stat_held_cycles  (stat_held),
    .o_stat_ex_overrides (stat_ovr)
`endif
  );

  logic       sc_inc, sc_clr;
  logic [3:0] sc_count;

  sat_counter #(.WIDTH(4)) u_sat (
    .clk   (clk),
    .inc   (sc_inc),
    .clr   (sc_clr),
    .count (sc_count)
  );

  // Reference: at most one outstanding redirect, held in a queue.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic          is_ex;
  } pend_t;
  pend_t       q[$];
  logic [31:0] m_red, m_held;
  logic [15:0] m_ovr;

  task automatic model_eval(output logic we, output logic [AW-1:0] pc,
                            output logic fi, output logic fd, output logic pe);
    we = 1'b0; pc = '0; fi = 1'b0; fd = 1'b0;
    pe = (q.size() != 0);
    if (ex_v) begin
      we = 1'b1; pc = ex_pc; fi = 1'b1; fd = 1'b1;
    end else if (q.size() != 0) begin
      we = 1'b1; pc = q[0].pc;
    end else if (id_v) begin
      we = 1'b1; pc = id_pc; fi = 1'b1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      q.delete();
      m_red = 0; m_held = 0; m_ovr = 0;
    end else begin
      if ((ex_v || (id_v && q.size() == 0)) && m_red != 32'hFFFF_FFFF) m_red = m_red + 1;
      if (q.size() != 0 && m_held != 32'hFFFF_FFFF) m_held = m_held + 1;
      if (ex_v && q.size() != 0 && !q[0].is_ex && m_ovr != 16'hFFFF) m_ovr = m_ovr + 1;
      if (stall) begin
        if (ex_v) begin
          q.delete();
          q.push_back('{pc: ex_pc, is_ex: 1'b1});
        end else if (id_v && q.size() == 0) begin
          q.push_back('{pc: id_pc, is_ex: 1'b0});
        end
      end else begin
        q.delete();
      end
    end
  endtask

  task automatic check_stats(input string name);
`ifdef FETCH_REDIRECT_STATS_EN
    checks++;
    if (stat_redirects !== m_red || stat_held !== m_held || stat_ovr !== m_ovr) begin
      errors++;
      $display("FAIL %s stats got red=%0d held=%0d ovr=%0d want red=%0d held=%0d ovr=%0d",
               name, stat_redirects, stat_held, stat_ovr, m_red, m_held, m_ovr);
    end
`else
    if (name.len() == 0) $display("unnamed stats check");
`endif
  endtask

  typedef struct {
    logic          rst, stall, exv;
    logic [AW-1:0] expc;
    logic          idv;
    logic [AW-1:0] idpc;
    logic          we;
    logic [AW-1:0] pc;
    logic          fi, fd, pe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic ev, input logic [AW-1:0] ep,
                     input logic iv, input logic [AW-1:0] ip, input logic we,
                     input logic [AW-1:0] pc, input logic fi, input logic fd, input logic pe);
    vecs.push_back('{r, s, ev, ep, iv, ip, we, pc, fi, fd, pe});
  endtask

  initial begin
    logic          e_we, e_fi, e_fd, e_pe;
    logic [AW-1:0] e_pc;

    rst = 1'b1; stall = 1'b0; ex_v = 1'b0; id_v = 1'b0; ex_pc = '0; id_pc = '0;
    sc_inc = 1'b0; sc_clr = 1'b1;
    m_red = 0; m_held = 0; m_ovr = 0;

    //   rst stall exv expc  idv idpc   we pc     fi fd pe
    add(1, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0);
    add(0, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0);
    add(0, 0, 0, 0,      1, 'h100,  1, 'h100,  1, 0, 0);
    add(0, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0);
    add(0, 0, 1, 'h200,  1, 'h300,  1, 'h200,  1, 1, 0);
    add(0, 1, 0, 0,      1, 'h40,   1, 'h40,   1, 0, 0);
    add(0, 1, 0, 0,      0, 0,      1, 'h40,   0, 0, 1);
    add(0, 1, 0, 0,      0, 0,      1, 'h40,   0, 0, 1);
    add(0, 0, 0, 0,      0, 0,      1, 'h40,   0, 0, 1);
    add(0, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0);
    add(0, 1, 0, 0,      1, 'h40,   1, 'h40,   1, 0, 0);
    add(0, 1, 1, 'h80,   0, 0,      1, 'h80,   1, 1, 1);
    add(0, 1, 0, 0,      1, 'h90,   1, 'h80,   0, 0, 1);
    add(0, 0, 0, 0,      0, 0,      1, 'h80,   0, 0, 1);
    add(0, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0);
    add(0, 1, 1, 'h80,   0, 0,      1, 'h80,   1, 1, 0);
    add(1, 1, 0, 0,      0, 0,      1, 'h80,   0, 0, 1);
    add(0, 1, 0, 0,      0, 0,      0, 0,      0, 0, 0);
    add(0, 0, 0, 0,      0, 0,      0, 0,      0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall;
      ex_v = vecs[i].exv; ex_pc = vecs[i].expc;
      id_v = vecs[i].idv; id_pc = vecs[i].idpc;
      #2;
      checks++;
      if ({load_we, load_pc, flush_if, flush_id, pending} !==
          {vecs[i].we, vecs[i].pc, vecs[i].fi, vecs[i].fd, vecs[i].pe}) begin
        errors++;
        $display("FAIL vec%0d got we=%b pc=%h fi=%b fd=%b pe=%b want we=%b pc=%h fi=%b fd=%b pe=%b",
                 i, load_we, load_pc, flush_if, flush_id, pending,
                 vecs[i].we, vecs[i].pc, vecs[i].fi, vecs[i].fd, vecs[i].pe);
      end
      check_stats($sformatf("vec%0d", i));
      model_update();
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 99) < 55);
      ex_v  = ($urandom_range(0, 99) < 20);
      id_v  = ($urandom_range(0, 99) < 35);
      ex_pc = AW'($urandom);
      id_pc = AW'($urandom);
      #2;
      model_eval(e_we, e_pc, e_fi, e_fd, e_pe);
      checks++;
      if ({load_we, load_pc, flush_if, flush_id, pending} !== {e_we, e_pc, e_fi, e_fd, e_pe}) begin
        errors++;
        $display("FAIL rand%0d got we=%b pc=%h fi=%b fd=%b pe=%b want we=%b pc=%h fi=%b fd=%b pe=%b",
                 i, load_we, load_pc, flush_if, flush_id, pending, e_we, e_pc, e_fi, e_fd, e_pe);
      end
      check_stats($sformatf("rand%0d", i));
      model_update();
    end

    @(negedge clk);
    sc_clr = 1'b0; sc_inc = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    checks++;
    if (sc_count !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold got %h want f", sc_count);
    end
    sc_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (sc_count !== 4'h0) begin
      errors++;
      $display("FAIL sat_clr got %h want 0", sc_count);
    end
    sc_clr = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    sc_inc = 1'b0;
    @(negedge clk);
    checks++;
    if (sc_count !== 4'h3) begin
      errors++;
      $display("FAIL sat_count got %h want 3", sc_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
